// File: rtl/core_pkg.sv
// Shared types, opcode constants and decode helpers for the accumulator core sequencer.
package core_pkg;

  localparam int OP_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  localparam logic [OP_BITS-1:0] OP_SHIFT = 4'b0000;
  localparam logic [OP_BITS-1:0] OP_BEQ   = 4'b0001;
  localparam logic [OP_BITS-1:0] OP_BR2   = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_BR3   = 4'b0011;
  localparam logic [OP_BITS-1:0] OP_LOAD  = 4'b0100;
  localparam logic [OP_BITS-1:0] OP_STORE = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_PUSH  = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_POP   = 4'b0111;
  localparam logic [OP_BITS-1:0] OP_DONE  = 4'b1111;

  function automatic logic is_branch(input logic [OP_BITS-1:0] op);
    return (op == OP_BEQ) || (op == OP_BR2) || (op == OP_BR3);
  endfunction

  // Opcodes that produce a register-file result when they retire.
  function automatic logic writes_reg(input logic [OP_BITS-1:0] op);
    return !is_branch(op) && (op != OP_STORE) && (op != OP_DONE);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/core_sequencer_pc_reg.sv
// Program counter register: async clear, then sync clear > load > increment.
module pc_reg #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem sequencer owning the PC of the accumulator core.
// Optional performance counters are built when CORE_SEQ_PERF_CNT_EN is defined.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic            ld_immed,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            dmem_ready,
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic            reg_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            busy,
  output logic            done
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     instr_retired,
  output logic [31:0]     cycle_count
`endif
);

  seq_state_t           state;
  seq_state_t           state_nxt;
  logic [OP_BITS-1:0]   op;
  logic                 is_mem_op;
  logic                 pc_clr;
  logic                 pc_load;
  logic                 pc_inc;
  logic                 retire;

  assign op        = OP_BITS'(opcode);
  assign is_mem_op = (op == OP_LOAD) || (op == OP_STORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      // ld_immed overrides the opcode: an immediate load never touches memory.
      S_DECODE: begin
        if (ld_immed)             state_nxt = S_EXEC;
        else if (op == OP_DONE)   state_nxt = S_HALT;
        else if (is_mem_op)       state_nxt = S_MEM;
        else                      state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = S_FETCH;
      S_MEM:    if (dmem_ready) state_nxt = S_FETCH;
      S_HALT:   if (!start) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    reg_we   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    pc_clr   = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE: begin
        busy   = 1'b0;
        pc_clr = 1'b1;
      end
      S_FETCH: begin
        ir_load = 1'b1;
      end
      S_DECODE: begin
        retire = !ld_immed && (op == OP_DONE);
      end
      S_EXEC: begin
        reg_we  = ld_immed || writes_reg(op);
        pc_load = !ld_immed && is_branch(op) && branch_taken;
        pc_inc  = !pc_load;
        retire  = 1'b1;
      end
      // Request is held until the memory answers; the PC only moves on completion.
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STORE);
        if (dmem_ready) begin
          reg_we = (op == OP_LOAD);
          pc_inc = 1'b1;
          retire = 1'b1;
        end
      end
      S_HALT: begin
        busy   = 1'b0;
        done   = 1'b1;
        pc_clr = !start;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pc_clr),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (branch_target),
    .pc     (pc)
  );

`ifdef CORE_SEQ_PERF_CNT_EN
  logic perf_clr;

  // A fresh run starts counting from zero; totals survive HALT and IDLE for readout.
  assign perf_clr = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      cycle_count   <= '0;
    end else if (perf_clr) begin
      instr_retired <= '0;
      cycle_count   <= '0;
    end else begin
      if (busy)   cycle_count   <= sat_inc32(cycle_count);
      if (retire) instr_retired <= sat_inc32(instr_retired);
    end
  end
`else
  logic perf_unused;
  assign perf_unused = retire;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction-level model plus per-cycle compare.
`timescale 1ns/1ps
module tb_core_sequencer;
  import core_pkg::*;

  localparam int PC_W = 10;
  localparam int OPW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [OPW-1:0]  opcode;
  logic            ld_immed;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            dmem_ready;
  logic [PC_W-1:0] pc;
  logic            ir_load, reg_we, dmem_req, dmem_we, busy, done;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [31:0]     instr_retired, cycle_count;
`endif

  core_sequencer #(.PC_W(PC_W), .OPW(OPW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .opcode        (opcode),
    .ld_immed      (ld_immed),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .dmem_ready    (dmem_ready),
    .pc            (pc),
    .ir_load       (ir_load),
    .reg_we        (reg_we),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .busy          (busy),
    .done          (done)
`ifdef CORE_SEQ_PERF_CNT_EN
    ,
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      op;
    logic            ld;
    logic            taken;
    logic [PC_W-1:0] tgt;
    int              wait_n;
  } instr_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            ir_load, reg_we, req, we, busy, done, st;
    logic [31:0]     ni, nc;
  } row_t;

  instr_t          prog[$];
  row_t            exp_q[$];
  int              checks = 0;
  int              failures = 0;
  int              row_idx = 0;
  bit              chk_en = 0;
  logic [PC_W-1:0] m_pc = '0;
  logic [31:0]     m_instr = '0;
  logic [31:0]     m_cyc = '0;
  logic [3:0]      ir_op;
  logic            ir_ld, ir_taken;
  logic [PC_W-1:0] ir_tgt;
  int              wait_left = 0;
  logic            man_mode, start_man, start_row;

  assign start = man_mode ? start_man : start_row;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  task automatic push_row(input logic [PC_W-1:0] p, input logic irl, input logic rwe,
                          input logic req, input logic we, input logic bsy, input logic dn,
                          input logic st, input logic ret, input logic clr);
    row_t r;
    r.pc = p; r.ir_load = irl; r.reg_we = rwe; r.req = req; r.we = we;
    r.busy = bsy; r.done = dn; r.st = st; r.ni = m_instr; r.nc = m_cyc;
    exp_q.push_back(r);
    if (bsy) m_cyc = m_cyc + 32'd1;
    if (ret) m_instr = m_instr + 32'd1;
    if (clr) begin m_cyc = '0; m_instr = '0; end
  endtask

  task automatic model_instr(input instr_t in);
    logic br, mem, is_st, is_ld;
    prog.push_back(in);
    br    = !in.ld && (in.op == 4'b0001 || in.op == 4'b0010 || in.op == 4'b0011);
    is_st = (in.op == 4'b0101);
    is_ld = (in.op == 4'b0100);
    mem   = !in.ld && (is_st || is_ld);
    push_row(m_pc, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    if (!in.ld && in.op == 4'b1111) begin
      push_row(m_pc, 0, 0, 0, 0, 1, 0, 1, 1, 0);
      return;
    end
    push_row(m_pc, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    if (!mem) begin
      push_row(m_pc, 0, in.ld || !(br || is_st), 0, 0, 1, 0, 1, 1, 0);
      m_pc = (br && in.taken) ? in.tgt : m_pc + 10'd1;
    end else begin
      repeat (in.wait_n) push_row(m_pc, 0, 0, 1, is_st, 1, 0, 1, 0, 0);
      push_row(m_pc, 0, is_ld, 1, is_st, 1, 0, 1, 1, 0);
      m_pc = m_pc + 10'd1;
    end
  endtask

  task automatic model_halt(input int n);
    for (int i = 0; i < n; i++) push_row(m_pc, 0, 0, 0, 0, 0, 1, (i < n - 1), 0, 0);
  endtask

  task automatic model_idle(input logic st);
    m_pc = '0;
    push_row(m_pc, 0, 0, 0, 0, 0, 0, st, 0, st);
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic ld, input logic tk,
                                input logic [PC_W-1:0] tg, input int w);
    instr_t i;
    i.op = op; i.ld = ld; i.taken = tk; i.tgt = tg; i.wait_n = w;
    return i;
  endfunction

  // ---------------- environment drive + per-cycle compare ----------------
  always @(negedge clk) begin : drive_cmp
    row_t   r;
    instr_t ins;
    if (ir_load === 1'b1 && prog.size() > 0) begin
      ins = prog.pop_front();
      ir_op = ins.op; ir_ld = ins.ld; ir_taken = ins.taken; ir_tgt = ins.tgt;
      wait_left = ins.wait_n;
    end
    if (dmem_req === 1'b1) begin
      dmem_ready = (wait_left == 0);
      if (wait_left > 0) wait_left = wait_left - 1;
    end else begin
      dmem_ready = 1'b1;
    end
    opcode = ir_op; ld_immed = ir_ld; branch_taken = ir_taken; branch_target = ir_tgt;
    #1;
    if (chk_en && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk($sformatf("row%0d.pc", row_idx),       32'(pc),       32'(r.pc));
      chk($sformatf("row%0d.ir_load", row_idx),  32'(ir_load),  32'(r.ir_load));
      chk($sformatf("row%0d.reg_we", row_idx),   32'(reg_we),   32'(r.reg_we));
      chk($sformatf("row%0d.dmem_req", row_idx), 32'(dmem_req), 32'(r.req));
      chk($sformatf("row%0d.dmem_we", row_idx),  32'(dmem_we),  32'(r.we));
      chk($sformatf("row%0d.busy", row_idx),     32'(busy),     32'(r.busy));
      chk($sformatf("row%0d.done", row_idx),     32'(done),     32'(r.done));
`ifdef CORE_SEQ_PERF_CNT_EN
      chk($sformatf("row%0d.instr_retired", row_idx), instr_retired, r.ni);
      chk($sformatf("row%0d.cycle_count", row_idx),   cycle_count,   r.nc);
`endif
      start_row = r.st;
      row_idx++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc"},       32'(pc),       32'd0);
    chk({tag, ".ir_load"},  32'(ir_load),  32'd0);
    chk({tag, ".reg_we"},   32'(reg_we),   32'd0);
    chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, ".dmem_we"},  32'(dmem_we),  32'd0);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".done"},     32'(done),     32'd0);
`ifdef CORE_SEQ_PERF_CNT_EN
    chk({tag, ".instr_retired"}, instr_retired, 32'd0);
    chk({tag, ".cycle_count"},   cycle_count,   32'd0);
`endif
  endtask

  initial begin
    int we_rows;
    rst_n = 1'b0; man_mode = 1'b1; start_man = 1'b1; start_row = 1'b1;
    ir_op = '0; ir_ld = 1'b0; ir_taken = 1'b0; ir_tgt = '0;
    opcode = '0; ld_immed = 1'b0; branch_taken = 1'b0; branch_target = '0; dmem_ready = 1'b1;

    // Run A: ALU, taken/not-taken branches, store with 2 waits, load, immediate, wrap, done at 7.
    model_idle(1'b1);
    model_instr(mk(4'b1000, 0, 0, 10'h000, 0));
    model_instr(mk(4'b0001, 0, 1, 10'h02A, 0));
    model_instr(mk(4'b0001, 0, 0, 10'h010, 0));
    model_instr(mk(4'b0101, 0, 0, 10'h000, 2));
    model_instr(mk(4'b0100, 0, 0, 10'h000, 0));
    model_instr(mk(4'b0100, 1, 0, 10'h000, 0));
    model_instr(mk(4'b0010, 0, 1, 10'h3FF, 0));
    model_instr(mk(4'b1000, 0, 0, 10'h000, 0));
    model_instr(mk(4'b0000, 0, 0, 10'h000, 0));
    model_instr(mk(4'b0011, 0, 1, 10'h007, 0));
    model_instr(mk(4'b1111, 0, 0, 10'h000, 0));

    chk("pin.cycle1_ir_load", 32'(exp_q[1].ir_load), 32'd1);
    chk("pin.cycle2_ir_load", 32'(exp_q[2].ir_load), 32'd0);
    chk("pin.cycle3_reg_we",  32'(exp_q[3].reg_we),  32'd1);
    chk("pin.cycle4_pc",      32'(exp_q[4].pc),      32'd1);
    chk("pin.runA_cycles",    m_cyc,                 32'd34);
    chk("pin.runA_instrs",    m_instr,               32'd11);
    chk("pin.runA_halt_pc",   32'(m_pc),             32'd7);
    we_rows = 0;
    foreach (exp_q[i]) if (exp_q[i].we) we_rows++;
    chk("pin.store_we_rows",  32'(we_rows),          32'd3);

    // start wiggles mid-run must be ignored while busy
    for (int i = 8; i <= 10; i++) exp_q[i].st = 1'b0;

    model_halt(4);
    model_idle(1'b1);
    // Run B: rerun after start release.
    model_instr(mk(4'b0110, 0, 0, 10'h000, 0));
    model_instr(mk(4'b0100, 0, 0, 10'h000, 1));
    model_instr(mk(4'b1111, 0, 0, 10'h000, 0));
    model_halt(2);
    model_idle(1'b0);

    #12;
    chk_all_zero("reset");

    @(posedge clk); #1;
    rst_n = 1'b1; man_mode = 1'b0; chk_en = 1'b1;

    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL timeout: %0d rows left expected 0", exp_q.size());
    end
    @(posedge clk); #2;
    chk_en = 1'b0; start_man = 1'b0; man_mode = 1'b1;

    // Run C: reset asserted in the middle of a stalled store.
    prog.push_back(mk(4'b0101, 0, 0, 10'h000, 5));
    start_man = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("runC.mem_req", 32'(dmem_req), 32'd1);
    chk("runC.mem_we",  32'(dmem_we),  32'd1);
    chk("runC.busy",    32'(busy),     32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midmem_reset");
    chk("midmem_reset.state", 32'(dut.state), 32'(S_IDLE));
    start_man = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;
    chk_all_zero("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
